// File: rtl/sha256_pkg.sv
// sha256_pkg -- shared definitions for the SHA-256 digest transmitter.
//   Holds the transmitter FSM state type, the default digest width and the
//   byte width used to serialise the digest.
//   Configuration macro: SHA_TX_CHECKSUM_EN adds the CSUM state.
package sha256_pkg;

   localparam int unsigned DIGEST_W_DEFAULT = 256;
   localparam int unsigned BYTE_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1
`ifdef SHA_TX_CHECKSUM_EN
      ,
      ST_CSUM = 2'd2
`endif
   } tx_state_e;

endpackage : sha256_pkg

// File: rtl/sha256_digest_tx.sv
// sha256_digest_tx -- serialises a captured digest as a byte stream with a
// valid/ready handshake, most significant byte first.
//   Configuration macro: SHA_TX_CHECKSUM_EN -- when defined, an extra byte
//   holding the XOR of all digest bytes is appended and carries tx_last.
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - synchronous active-high reset
//   dig_load  - one-cycle request to capture dig_in (accepted only in IDLE)
//   dig_in    - digest word, bits [DIGEST_W-1 -: 8] are byte 0
//   abort     - cancels an in-progress frame without a done pulse
//   busy      - frame in progress
//   tx_data   - current output byte
//   tx_valid  - tx_data valid
//   tx_ready  - consumer accepts on tx_valid & tx_ready
//   tx_last   - final byte of the frame
//   done      - one-cycle pulse after the final byte handshake
module sha256_digest_tx
   import sha256_pkg::*;
#(
   parameter int unsigned DIGEST_W = DIGEST_W_DEFAULT,
   parameter int unsigned NBYTES   = DIGEST_W / BYTE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dig_load,
   input  logic [DIGEST_W-1:0] dig_in,
   input  logic                abort,
   output logic                busy,
   output logic [BYTE_W-1:0]   tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                tx_last,
   output logic                done
);

   localparam int unsigned CNT_W = $clog2(NBYTES + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

   tx_state_e             state_q, state_d;
   logic [DIGEST_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic                  done_q,  done_d;
`ifdef SHA_TX_CHECKSUM_EN
   logic [BYTE_W-1:0]     csum_q,  csum_d;
`endif

   logic [BYTE_W-1:0]     top_byte;
   logic                  hs;

   assign top_byte = shreg_q[DIGEST_W-1 -: BYTE_W];
   assign hs       = (state_q != ST_IDLE) && tx_ready;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef SHA_TX_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (dig_load) begin
               shreg_d = dig_in;
               cnt_d   = '0;
`ifdef SHA_TX_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // A byte handshaken together with abort still counts as consumed.
            if (hs) begin
               shreg_d = {shreg_q[DIGEST_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               cnt_d   = cnt_q + 1'b1;
`ifdef SHA_TX_CHECKSUM_EN
               csum_d  = csum_q ^ top_byte;
`endif
            end
            if (abort) begin
               state_d = ST_IDLE;
            end else if (hs && (cnt_q == LAST_IDX)) begin
`ifdef SHA_TX_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_IDLE;
               done_d  = 1'b1;
`endif
            end
         end
`ifdef SHA_TX_CHECKSUM_EN
         ST_CSUM: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (hs) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef SHA_TX_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef SHA_TX_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Outputs are forced low while rst is asserted, not only after the edge.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = '0;
      tx_last  = 1'b0;
      busy     = 1'b0;
      done     = done_q && !rst;
      if (!rst) begin
         unique case (state_q)
            ST_SEND: begin
               tx_valid = 1'b1;
               busy     = 1'b1;
               tx_data  = top_byte;
`ifndef SHA_TX_CHECKSUM_EN
               tx_last  = (cnt_q == LAST_IDX);
`endif
            end
`ifdef SHA_TX_CHECKSUM_EN
            ST_CSUM: begin
               tx_valid = 1'b1;
               busy     = 1'b1;
               tx_data  = csum_q;
               tx_last  = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule : sha256_digest_tx

// File: tb/tb_sha256_digest_tx.sv
// tb_sha256_digest_tx -- directed and randomised checks of sha256_digest_tx
// against a queue-based frame model.
module tb_sha256_digest_tx;

   localparam int DW = 256;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dig_load = 1'b0;
   logic [DW-1:0] dig_in = '0;
   logic          abort = 1'b0;
   logic          tx_ready = 1'b0;
   logic          busy, tx_valid, tx_last, done;
   logic [7:0]    tx_data;

   sha256_digest_tx #(.DIGEST_W(DW)) dut (
      .clk(clk), .rst(rst), .dig_load(dig_load), .dig_in(dig_in),
      .abort(abort), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_last(tx_last), .done(done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: bytes still to send in the current frame, plus done pending.
   logic [7:0] m_q[$];
   logic       m_active = 1'b0;
   logic       m_done = 1'b0;

   function automatic logic [DW-1:0] ramp_digest();
      logic [DW-1:0] d;
      for (int i = 0; i < NB; i++) d[DW-1-8*i -: 8] = 8'(i);
      return d;
   endfunction

   function automatic logic [DW-1:0] rand_digest();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: at negedge compare outputs against the model, then update the
   // model for the coming edge and drive the new inputs.
   task automatic tick(input logic r, input logic ld, input logic [DW-1:0] d,
                       input logic ab, input logic rdy);
      logic [7:0] x;
      @(negedge clk);
      check("tx_valid", {7'd0, tx_valid}, {7'd0, m_active && !rst});
      check("busy",     {7'd0, busy},     {7'd0, m_active && !rst});
      check("tx_data",  tx_data,          (m_active && !rst) ? m_q[0] : 8'h00);
      check("tx_last",  {7'd0, tx_last},  {7'd0, m_active && !rst && m_q.size() == 1});
      check("done",     {7'd0, done},     {7'd0, m_done && !rst});
      if (r) begin
         m_active = 1'b0; m_done = 1'b0; m_q.delete();
      end else if (!m_active) begin
         m_done = 1'b0;
         if (ld) begin
            m_q.delete();
            x = 8'h00;
            for (int i = 0; i < NB; i++) begin
               m_q.push_back(d[DW-1-8*i -: 8]);
               x ^= d[DW-1-8*i -: 8];
            end
`ifdef SHA_TX_CHECKSUM_EN
            m_q.push_back(x);
`endif
            m_active = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (rdy) void'(m_q.pop_front());
         if (ab) begin
            m_active = 1'b0; m_q.delete();
         end else if (m_q.size() == 0) begin
            m_active = 1'b0; m_done = 1'b1;
         end
      end
      rst = r; dig_load = ld; dig_in = d; abort = ab; tx_ready = rdy;
   endtask

   task automatic idle_ready(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
   endtask

   logic [DW-1:0] ramp, ff_d, aa_d, z5a;
   logic [7:0]    last_seen;

   initial begin
      ramp = ramp_digest();
      ff_d = '1;
      aa_d = {32{8'hAA}};
      z5a  = '0;
      z5a[DW-1 -: 8] = 8'h5A;

      // Reset state
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
      idle_ready(2);

      // Ramp frame, ready always high; first byte 1 cycle after load
      tick(1'b0, 1'b1, ramp, 1'b0, 1'b1);
      last_seen = 8'hFF;
      for (int i = 0; i < NB + 4; i++) begin
         tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
         if (tx_valid && tx_last) last_seen = tx_data;
      end
`ifdef SHA_TX_CHECKSUM_EN
      check("csum_ramp", last_seen, 8'h00);
`else
      check("last_ramp", last_seen, 8'h1F);
`endif

      // Ramp frame with ready toggling randomly
      tick(1'b0, 1'b1, ramp, 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3 * NB; i++)
         tick(1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
      idle_ready(4);

      // Load while busy at byte 10 is ignored
      tick(1'b0, 1'b1, ramp, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, ff_d, 1'b0, 1'b1);
      idle_ready(NB);
      // Load coinciding with the final handshake is ignored
      tick(1'b0, 1'b1, ramp, 1'b0, 1'b1);
      for (int i = 0; i < NB - 1; i++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
`ifdef SHA_TX_CHECKSUM_EN
      tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
`endif
      tick(1'b0, 1'b1, ff_d, 1'b0, 1'b1);
      idle_ready(4);

      // Abort at byte 5, then load all-0xAA
      tick(1'b0, 1'b1, ramp, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
      idle_ready(2);
      tick(1'b0, 1'b1, aa_d, 1'b0, 1'b1);
      idle_ready(NB + 4);

      // Reset at byte 20, then a full frame
      tick(1'b0, 1'b1, ramp, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, ff_d, 1'b1, 1'b1);
      idle_ready(2);
      tick(1'b0, 1'b1, rand_digest(), 1'b0, 1'b1);
      idle_ready(NB + 4);

      // Single non-zero byte digest (checksum 0x5A when enabled)
      tick(1'b0, 1'b1, z5a, 1'b0, 1'b1);
      last_seen = 8'h00;
      for (int i = 0; i < NB + 4; i++) begin
         tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
         if (tx_valid && tx_last) last_seen = tx_data;
      end
`ifdef SHA_TX_CHECKSUM_EN
      check("csum_5a", last_seen, 8'h5A);
`else
      check("last_5a", last_seen, 8'h00);
`endif

      // Random mix of loads, aborts, resets and back-pressure
      for (int i = 0; i < 600; i++)
         tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
              rand_digest(), ($urandom_range(0, 49) == 0),
              1'($urandom_range(0, 1)));
      idle_ready(NB + 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_sha256_digest_tx
